// File: rtl/load_store_unit.sv
// Load/store unit bridging core requests to a 32-bit-read / 64-bit-or-byte-write data memory.
// Multi-beat accesses are sequenced by a small IDLE/BUSY FSM with a beat down-counter.
//
// state | meaning
// IDLE  | ready for a request; error responses are issued from here
// BUSY  | issuing memory beats; beats_left == 0 marks the final beat
module load_store_unit #(
    parameter logic [63:0] DATA_START = 64'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWU = 4'd5;
    localparam logic [3:0] OP_LD  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SD  = 4'd11;

    // The bench memory model indexes by the low address bits, so the segment base must be doubleword aligned.
    if (DATA_START[2:0] != 3'd0) begin : g_base_check
        $error("DATA_START must be doubleword aligned");
    end

    logic [0:0]  state;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [23:0] wdata_q;
    logic [31:0] lo_q;
    logic [1:0]  beats_left;

    logic        op_legal;
    logic        misaligned;
    logic [1:0]  beats_m1;
    logic [31:0] rd_shift;
    logic [63:0] load_result;

    assign req_ready = (state == IDLE) && !reset;

    always_comb begin
        op_legal   = 1'b1;
        misaligned = 1'b0;
        beats_m1   = 2'd0;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: begin
                misaligned = 1'b0;
            end
            OP_LH, OP_LHU: begin
                misaligned = req_addr[0];
            end
            OP_SH: begin
                misaligned = req_addr[0];
                beats_m1   = 2'd1;
            end
            OP_LW, OP_LWU: begin
                misaligned = |req_addr[1:0];
            end
            OP_SW: begin
                misaligned = |req_addr[1:0];
                beats_m1   = 2'd3;
            end
            OP_LD: begin
                misaligned = |req_addr[2:0];
                beats_m1   = 2'd1;
            end
            OP_SD: begin
                misaligned = |req_addr[2:0];
            end
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    // Final-beat load data; LD concatenates the high word with the low word captured on beat 0.
    always_comb begin
        rd_shift    = mem_rdata >> {off_q, 3'b000};
        load_result = 64'd0;
        case (op_q)
            OP_LB:   load_result = {{56{rd_shift[7]}}, rd_shift[7:0]};
            OP_LBU:  load_result = {56'd0, rd_shift[7:0]};
            OP_LH:   load_result = {{48{rd_shift[15]}}, rd_shift[15:0]};
            OP_LHU:  load_result = {48'd0, rd_shift[15:0]};
            OP_LW:   load_result = {{32{rd_shift[31]}}, rd_shift};
            OP_LWU:  load_result = {32'd0, rd_shift};
            OP_LD:   load_result = {mem_rdata, lo_q};
            default: load_result = 64'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            op_q        <= 4'd0;
            off_q       <= 2'd0;
            wdata_q     <= 24'd0;
            lo_q        <= 32'd0;
            beats_left  <= 2'd0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 64'd0;
            mem_addr    <= 64'd0;
            mem_wdata   <= 64'd0;
            mem_word_we <= 1'b0;
            mem_byte_we <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    mem_word_we <= 1'b0;
                    mem_byte_we <= 1'b0;
                    if (req_valid) begin
                        op_q    <= req_op;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata[31:8];
                        if (!op_legal || misaligned) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 64'd0;
                        end else begin
                            state       <= BUSY;
                            beats_left  <= beats_m1;
                            mem_addr    <= req_addr;
                            mem_wdata   <= (req_op == OP_SD) ? req_wdata : {56'd0, req_wdata[7:0]};
                            mem_word_we <= (req_op == OP_SD);
                            mem_byte_we <= req_op[3] && (req_op != OP_SD);
                        end
                    end
                end
                BUSY: begin
                    if (beats_left == 2'd0) begin
                        state       <= IDLE;
                        resp_valid  <= 1'b1;
                        resp_rdata  <= load_result;
                        mem_word_we <= 1'b0;
                        mem_byte_we <= 1'b0;
                    end else begin
                        // Only LD among loads has a non-final beat; it yields the low word.
                        beats_left <= beats_left - 2'd1;
                        mem_addr   <= mem_addr + ((op_q == OP_LD) ? 64'd4 : 64'd1);
                        mem_wdata  <= {56'd0, wdata_q[7:0]};
                        wdata_q    <= {8'd0, wdata_q[23:8]};
                        if (!op_q[3]) begin
                            lo_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array data memory model
// (negedge writes, combinational 32-bit reads selected by mem_addr[2]).
module tb_load_store_unit;

    localparam logic [63:0] D = 64'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = 4'd0;
    logic [63:0] req_addr = 64'd0;
    logic [63:0] req_wdata = 64'd0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_word_we;
    logic        mem_byte_we;
    logic [31:0] mem_rdata;

    load_store_unit #(.DATA_START(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_word_we(mem_word_we),
        .mem_byte_we(mem_byte_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem_b [0:127];

    assign mem_rdata = {mem_b[{mem_addr[6:2], 2'd3}], mem_b[{mem_addr[6:2], 2'd2}],
                        mem_b[{mem_addr[6:2], 2'd1}], mem_b[{mem_addr[6:2], 2'd0}]};

    always @(negedge clk) begin
        if (mem_word_we)
            for (int k = 0; k < 8; k++)
                mem_b[{mem_addr[6:3], 3'(k)}] = mem_wdata[8*k +: 8];
        if (mem_byte_we)
            mem_b[mem_addr[6:0]] = mem_wdata[7:0];
    end

    int checks = 0;
    int errors = 0;
    logic [63:0] lg_addr [8];
    logic [63:0] lg_data [8];
    int n_word, n_byte, lat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at the current negedge and follow it through to its response.
    task automatic do_req(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                          input int exp_lat, input logic exp_err, input logic [63:0] exp_rd,
                          input int exp_word, input int exp_byte, input string tag);
        req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        chk({tag, " ready"}, {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        n_word = 0; n_byte = 0; lat = 1;
        while (!resp_valid && lat < 12) begin
            if (lat <= 8) begin
                lg_addr[lat-1] = mem_addr;
                lg_data[lat-1] = mem_wdata;
            end
            chk({tag, " we_excl"}, {63'd0, mem_word_we & mem_byte_we}, 64'd0);
            n_word += int'(mem_word_we);
            n_byte += int'(mem_byte_we);
            @(negedge clk);
            lat++;
        end
        chk({tag, " resp_valid"}, {63'd0, resp_valid}, 64'd1);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " err"}, {63'd0, resp_err}, {63'd0, exp_err});
        chk({tag, " rdata"}, resp_rdata, exp_rd);
        chk({tag, " word_beats"}, 64'(n_word), 64'(exp_word));
        chk({tag, " byte_beats"}, 64'(n_byte), 64'(exp_byte));
        @(negedge clk);
        chk({tag, " pulse"}, {63'd0, resp_valid}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem_b[i] = 8'h00;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", {63'd0, req_ready}, 64'd0);
        chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst mem_addr", mem_addr, 64'd0);
        chk("rst we", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);

        do_req(4'd11, D, 64'h1122334455667788, 2, 1'b0, 64'd0, 1, 0, "sd");
        chk("sd addr", lg_addr[0], D);
        chk("sd wdata", lg_data[0], 64'h1122334455667788);

        do_req(4'd6, D, 64'd0, 3, 1'b0, 64'h1122334455667788, 0, 0, "ld");
        chk("ld beat0 addr", lg_addr[0], D);
        chk("ld beat1 addr", lg_addr[1], D + 64'd4);

        do_req(4'd10, D + 64'd4, 64'hAABBCCDD, 5, 1'b0, 64'd0, 0, 4, "sw");
        chk("sw b0 addr", lg_addr[0], D + 64'd4);
        chk("sw b1 addr", lg_addr[1], D + 64'd5);
        chk("sw b2 addr", lg_addr[2], D + 64'd6);
        chk("sw b3 addr", lg_addr[3], D + 64'd7);
        chk("sw b0 data", lg_data[0], 64'hDD);
        chk("sw b1 data", lg_data[1], 64'hCC);
        chk("sw b2 data", lg_data[2], 64'hBB);
        chk("sw b3 data", lg_data[3], 64'hAA);

        do_req(4'd4, D + 64'd4, 64'd0, 2, 1'b0, 64'hFFFFFFFFAABBCCDD, 0, 0, "lw");
        do_req(4'd5, D + 64'd4, 64'd0, 2, 1'b0, 64'h00000000AABBCCDD, 0, 0, "lwu");

        do_req(4'd8, D + 64'd3, 64'h123456789ABCDE80, 2, 1'b0, 64'd0, 0, 1, "sb");
        chk("sb data", lg_data[0], 64'h80);
        do_req(4'd0, D + 64'd3, 64'd0, 2, 1'b0, 64'hFFFFFFFFFFFFFF80, 0, 0, "lb");
        do_req(4'd1, D + 64'd3, 64'd0, 2, 1'b0, 64'h0000000000000080, 0, 0, "lbu");

        do_req(4'd2, D + 64'd6, 64'd0, 2, 1'b0, 64'hFFFFFFFFFFFFAABB, 0, 0, "lh hi");
        do_req(4'd3, D + 64'd6, 64'd0, 2, 1'b0, 64'h000000000000AABB, 0, 0, "lhu hi");
        do_req(4'd2, D + 64'd2, 64'd0, 2, 1'b0, 64'hFFFFFFFFFFFF8066, 0, 0, "lh lo");

        do_req(4'd9, D + 64'd8, 64'hFFFF1234, 3, 1'b0, 64'd0, 0, 2, "sh");
        chk("sh b1 addr", lg_addr[1], D + 64'd9);
        chk("sh b1 data", lg_data[1], 64'h12);
        do_req(4'd3, D + 64'd8, 64'd0, 2, 1'b0, 64'h0000000000001234, 0, 0, "lhu sh");

        do_req(4'd6, D, 64'd0, 3, 1'b0, 64'hAABBCCDD80667788, 0, 0, "ld merged");

        // Error responses
        do_req(4'd4, D + 64'd2, 64'd0, 1, 1'b1, 64'd0, 0, 0, "lw misaligned");
        do_req(4'd7, D, 64'd0, 1, 1'b1, 64'd0, 0, 0, "illegal op");
        do_req(4'd11, D + 64'd4, 64'h55, 1, 1'b1, 64'd0, 0, 0, "sd misaligned");
        do_req(4'd3, D + 64'd1, 64'd0, 1, 1'b1, 64'd0, 0, 0, "lhu misaligned");

        do_req(4'd6, D, 64'd0, 3, 1'b0, 64'hAABBCCDD80667788, 0, 0, "ld pre_rst");

        // Reset during SW beat 2
        req_op = 4'd10; req_addr = D + 64'd16; req_wdata = 64'h01020304; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort ready", {63'd0, req_ready}, 64'd0);
        chk("abort resp", {62'd0, resp_valid, resp_err}, 64'd0);
        chk("abort rdata", resp_rdata, 64'd0);
        chk("abort mem_addr", mem_addr, 64'd0);
        chk("abort mem_wdata", mem_wdata, 64'd0);
        chk("abort we", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort release ready", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no resp", {63'd0, resp_valid}, 64'd0);
        end
        do_req(4'd4, D + 64'd16, 64'd0, 2, 1'b0, 64'h0000000000000304, 0, 0, "lw partial");

        // Back-to-back SB then LBU with req_valid held
        req_op = 4'd8; req_addr = D + 64'd24; req_wdata = 64'h5A; req_valid = 1'b1;
        chk("b2b sb ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        chk("b2b sb beat", {62'd0, mem_word_we, mem_byte_we}, 64'd1);
        chk("b2b busy ready", {63'd0, req_ready}, 64'd0);
        req_op = 4'd1; req_wdata = 64'd0;
        @(negedge clk);
        chk("b2b sb resp", {62'd0, resp_valid, resp_err}, 64'd2);
        chk("b2b resp ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b lbu addr", mem_addr, D + 64'd24);
        chk("b2b lbu no_we", {62'd0, mem_word_we, mem_byte_we}, 64'd0);
        @(negedge clk);
        chk("b2b lbu resp", {63'd0, resp_valid}, 64'd1);
        chk("b2b lbu rdata", resp_rdata, 64'h5A);
        @(negedge clk);
        chk("b2b lbu pulse", {63'd0, resp_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_START, default 64'h10000000, base byte address of the data segment; used only in verification address values.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_op  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 8 SB, 9 SH, 10 SW, 11 SD; other codes illegal.
REQ-007 SHALL have port req_addr  input  64  byte address.
REQ-008 SHALL have port req_wdata  input  64  store data, right-aligned.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  64  load result; 0 for stores and errors.
REQ-011 SHALL have port resp_err  output  1  misaligned address or illegal op; valid with resp_valid.
REQ-012 SHALL have port mem_addr  output  64  byte address to data memory.
REQ-013 SHALL have port mem_wdata  output  64  write data to data memory.
REQ-014 SHALL have port mem_word_we  output  1  full 64-bit doubleword write enable.
REQ-015 SHALL have port mem_byte_we  output  1  byte write enable; memory writes mem_wdata[7:0] at byte mem_addr[2:0].
REQ-016 SHALL have port mem_rdata  input  32  combinational read data; the 32-bit word selected by mem_addr[2].

Function
REQ-017 SHALL implement states IDLE and BUSY; req_ready = 1 exactly when state is IDLE and reset is low.
REQ-018 SHALL accept a request at a posedge where req_valid && req_ready, latching op, addr, wdata.
REQ-019 SHALL perform alignment checks on acceptance: LH/LHU/SH need addr[0]=0; LW/LWU/SW need addr[1:0]=0; LD/SD need addr[2:0]=0; byte ops are always aligned.
REQ-020 SHALL, on misaligned or illegal acceptance, stay in IDLE, issue no memory beat, and pulse resp_valid=1, resp_err=1, resp_rdata=0 in the following cycle.
REQ-021 SHALL use beat counts LB/LBU/LH/LHU/LW/LWU/SB/SD = 1, LD/SH = 2, SW = 4; one beat per clock cycle; the first beat occupies the cycle after acceptance.
REQ-022 SHALL drive mem_addr, mem_wdata, mem_word_we and mem_byte_we from registers so they are stable for a whole beat cycle, including the memory's negedge write.
REQ-023 SHALL hold mem_word_we and mem_byte_we at 0 outside beat cycles; both SHALL never be 1 together.
REQ-024 SHALL perform loads as LD beat0 at addr (low word) and beat1 at addr+4 (high word); all other loads use one beat at addr.
REQ-025 SHALL extract load data from mem_rdata at byte offset addr[1:0]: LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend.
REQ-026 SHALL perform SB as one byte beat at addr with wdata[7:0], and SD as one word beat with mem_wdata = wdata.
REQ-027 SHALL perform SH/SW as byte beats i = 0..N-1 at addr+i with mem_wdata[7:0] = wdata[8i+7:8i], in ascending address order.
REQ-028 SHALL compute all address increments modulo 2^64.
REQ-029 SHALL, at the posedge ending the last beat, return to IDLE and pulse resp_valid for exactly one cycle with resp_err=0; latency is beats+1 cycles from acceptance to resp_valid.
REQ-030 SHALL allow a new request to be accepted in the same cycle resp_valid is high (back-to-back).
REQ-031 SHALL hold resp_rdata at its value until the next resp_valid.

Reset
REQ-032 SHALL, while reset is high, force state IDLE, req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_word_we=0, mem_byte_we=0.
REQ-033 SHALL abort any in-flight operation on reset with no response; bytes already written stay written.

Verification
REQ-034 SHALL cover SD 0x1122334455667788 to DATA_START then LD from DATA_START -> SD in 1 beat with word_we, LD resp_rdata 0x1122334455667788 three cycles after acceptance.
REQ-035 SHALL cover SW 0xAABBCCDD to DATA_START+4 -> four byte_we beats at +4..+7 with data DD, CC, BB, AA; then LW -> 0xFFFFFFFFAABBCCDD and LWU -> 0x00000000AABBCCDD.
REQ-036 SHALL cover a byte at DATA_START+3 holding 0x80 -> LB returns 0xFFFFFFFFFFFFFF80 and LBU returns 0x80.
REQ-037 SHALL cover LW at DATA_START+2 and op code 7 -> no write enables, resp_err=1 one cycle after acceptance.
REQ-038 SHALL cover reset asserted during SW beat 2 -> all outputs 0 immediately; no resp_valid; req_ready=1 after release.
REQ-039 SHALL cover back-to-back SB then LBU to the same address with req_valid held high -> second request accepted in the SB resp_valid cycle and returns the stored byte.
